gac_regfile_wr: RTL and testbench

Write side of the 32 × 32-bit register file: it decodes the write-back address into one-hot enables, stores the 32 registers and presents them flattened to the 32-to-1 read multiplexors. It also keeps a pending-write scoreboard: one busy bit per register, set when an instruction that will write that register issues and cleared at its write-back. The block sits between the write-back stage and the decode-stage operand muxes and hazard unit.

---
 rtl/gac_regfile_wr_pkg.sv | 16 +
 rtl/gac_dec_5t32.sv | 15 +
 rtl/gac_regfile_wr.sv | 65 ++++++
 tb/tb_gac_regfile_wr.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gac_regfile_wr_pkg.sv
// rtl/gac_regfile_wr_pkg.sv - shared sizes and flat-slice helper for the register file
package gac_regfile_wr_pkg;

  localparam int NREGS  = 32;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // Register idx lives at bits [idx*WIDTH +: WIDTH] of the flattened bus.
  function automatic logic [WIDTH-1:0] reg_slice(input logic [NREGS*WIDTH-1:0] flat,
                                                 input logic [ADDR_W-1:0]      idx);
    return flat[int'(idx)*WIDTH +: WIDTH];
  endfunction

endpackage

// File: rtl/gac_dec_5t32.sv
// rtl/gac_dec_5t32.sv - combinational 5-to-32 one-hot decoder with enable
module gac_dec_5t32
  import gac_regfile_wr_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREGS-1:0]  onehot
);

  always_comb begin
    onehot       = '0;
    onehot[addr] = en;
  end

endmodule

// File: rtl/gac_regfile_wr.sv
// rtl/gac_regfile_wr.sv - register file write side with pending-write scoreboard
module gac_regfile_wr
  import gac_regfile_wr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      issue_addr,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic [NREGS-1:0]       busy
);

  logic [NREGS-1:0] wr_dec;
  logic [NREGS-1:0] set_dec;
  logic             unused_dec0;

  gac_dec_5t32 u_wr_dec (
    .en     (we),
    .addr   (waddr),
    .onehot (wr_dec)
  );

  gac_dec_5t32 u_set_dec (
    .en     (issue_en),
    .addr   (issue_addr),
    .onehot (set_dec)
  );

  // Register 0 is hardwired: its decoder outputs are deliberately ignored.
  assign unused_dec0 = wr_dec[REG_ZERO] | set_dec[REG_ZERO];

  logic [WIDTH-1:0] regs_q [1:NREGS-1];
  logic [NREGS-1:1] busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_dec[i]) begin
          regs_q[i] <= wdata;
        end
      end
      // A new producer issuing on the retiring register keeps it busy.
      busy_q <= set_dec[NREGS-1:1] | (busy_q & ~wr_dec[NREGS-1:1]);
    end
  end

  assign regs_flat[WIDTH-1:0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign busy = {busy_q, 1'b0};

endmodule

// File: tb/tb_gac_regfile_wr.sv
// tb/tb_gac_regfile_wr.sv - scoreboard-driven bench for gac_regfile_wr
module tb_gac_regfile_wr;
  import gac_regfile_wr_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [WIDTH-1:0]       wdata;
  logic                   issue_en;
  logic [ADDR_W-1:0]      issue_addr;
  logic [NREGS*WIDTH-1:0] regs_flat;
  logic [NREGS-1:0]       busy;

  gac_regfile_wr #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .regs_flat  (regs_flat),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREGS*WIDTH-1:0] flat;
    logic [NREGS-1:0]       busy;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  int               errors = 0;
  int               checks = 0;

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
  endfunction

  function automatic logic [NREGS*WIDTH-1:0] model_flat();
    logic [NREGS*WIDTH-1:0] f;
    for (int i = 0; i < NREGS; i++) f[i*WIDTH +: WIDTH] = m_regs[i];
    return f;
  endfunction

  // Drive one strobe cycle, push the model's post-edge prediction, then pass the edge.
  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia);
    exp_t e;
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; issue_en = ie; issue_addr = ia;
    if (w && wa != 0) m_regs[wa] = wd;
    if (w) m_busy[wa] = 1'b0;
    if (ie && ia != 0) m_busy[ia] = 1'b1;
    m_busy[0] = 1'b0;
    e.flat = model_flat();
    e.busy = m_busy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    we = 1'b0; issue_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; we = 1'b1; waddr = 5'd4; wdata = 32'h1111_2222;
    issue_en = 1'b1; issue_addr = 5'd6;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (regs_flat !== '0) begin
      errors++; $display("FAIL reset_regs: got %h expected 0", regs_flat);
    end
    checks++;
    if (busy !== '0) begin
      errors++; $display("FAIL reset_busy: got %h expected 0", busy);
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0; issue_en = 1'b0;
  endtask

  task automatic test_write_all();
    exp_t e;
    logic [31:0] want;
    for (int i = 1; i < NREGS; i++) begin
      want = 32'hA5A5_0000 + 32'(i);
      drive(1'b1, 5'(i), want, 1'b0, 5'd0);
      e = exp_q.pop_front();
      checks++;
      if (regs_flat !== e.flat) begin
        errors++; $display("FAIL write_all_flat[%0d]: got %h expected %h", i, regs_flat, e.flat);
      end
      checks++;
      if (reg_slice(regs_flat, 5'(i)) !== want) begin
        errors++; $display("FAIL write_all_slice[%0d]: got %h expected %h", i, reg_slice(regs_flat, 5'(i)), want);
      end
      checks++;
      if (busy !== e.busy) begin
        errors++; $display("FAIL write_all_busy[%0d]: got %h expected %h", i, busy, e.busy);
      end
    end
  endtask

  task automatic test_reg_zero();
    exp_t e;
    drive(1'b1, REG_ZERO, 32'hFFFF_FFFF, 1'b1, REG_ZERO);
    e = exp_q.pop_front();
    checks++;
    if (reg_slice(regs_flat, REG_ZERO) !== 32'h0) begin
      errors++; $display("FAIL reg_zero_slice: got %h expected 0", reg_slice(regs_flat, REG_ZERO));
    end
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL reg_zero_busy: got %b expected 0", busy[0]);
    end
    checks++;
    if (regs_flat !== e.flat) begin
      errors++; $display("FAIL reg_zero_flat: got %h expected %h", regs_flat, e.flat);
    end
  endtask

  task automatic test_lifecycle();
    exp_t e;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    e = exp_q.pop_front();
    checks++;
    if (busy !== 32'h0000_0080 || busy !== e.busy) begin
      errors++; $display("FAIL lifecycle_set: got %h expected 00000080", busy);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    e = exp_q.pop_front();
    checks++;
    if (busy !== 32'h0000_0080) begin
      errors++; $display("FAIL lifecycle_hold: got %h expected 00000080", busy);
    end
    drive(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0);
    e = exp_q.pop_front();
    checks++;
    if (busy !== 32'h0) begin
      errors++; $display("FAIL lifecycle_clear: got %h expected 0", busy);
    end
    checks++;
    if (reg_slice(regs_flat, 5'd7) !== 32'h1234_5678 || regs_flat !== e.flat) begin
      errors++; $display("FAIL lifecycle_data: got %h expected 12345678", reg_slice(regs_flat, 5'd7));
    end
  endtask

  task automatic test_set_clear_same();
    exp_t e;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    e = exp_q.pop_front();
    checks++;
    if (busy[9] !== 1'b1) begin
      errors++; $display("FAIL same_pre_busy: got %b expected 1", busy[9]);
    end
    drive(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1, 5'd9);
    e = exp_q.pop_front();
    checks++;
    if (reg_slice(regs_flat, 5'd9) !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL same_data: got %h expected deadbeef", reg_slice(regs_flat, 5'd9));
    end
    checks++;
    if (busy[9] !== 1'b1 || busy !== e.busy) begin
      errors++; $display("FAIL same_busy: got %h expected %h", busy, e.busy);
    end
  endtask

  task automatic test_independent();
    exp_t e;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    e = exp_q.pop_front();
    drive(1'b1, 5'd5, 32'h0BAD_F00D, 1'b1, 5'd3);
    e = exp_q.pop_front();
    checks++;
    if (busy[3] !== 1'b1 || busy[5] !== 1'b0) begin
      errors++; $display("FAIL indep_busy: got b3=%b b5=%b expected b3=1 b5=0", busy[3], busy[5]);
    end
    checks++;
    if (busy !== e.busy || regs_flat !== e.flat) begin
      errors++; $display("FAIL indep_state: got busy %h expected %h", busy, e.busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int n = 0; n < 60; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      e = exp_q.pop_front();
      checks++;
      if (regs_flat !== e.flat || busy !== e.busy) begin
        errors++; $display("FAIL b2b[%0d]: got busy %h expected %h", n, busy, e.busy);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 1; i < NREGS; i++) begin
      drive(1'b1, 5'(i), 32'h5000_0000 + 32'(i), 1'b0, 5'd0);
      e = exp_q.pop_front();
    end
    for (int i = 8; i < 12; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
      e = exp_q.pop_front();
    end
    checks++;
    if (busy !== 32'h0000_0F00 || regs_flat !== e.flat) begin
      errors++; $display("FAIL async_setup: got busy %h expected 00000f00", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (regs_flat !== '0 || busy !== '0) begin
      errors++; $display("FAIL async_immediate: got busy %h regs nonzero=%b expected 0", busy, |regs_flat);
    end
    we = 1'b1; waddr = 5'd4; wdata = 32'hCAFE_F00D; issue_en = 1'b1; issue_addr = 5'd12;
    @(posedge clk);
    #1;
    checks++;
    if (regs_flat !== '0 || busy !== '0) begin
      errors++; $display("FAIL async_discard: got busy %h slice4 %h expected 0", busy, reg_slice(regs_flat, 5'd4));
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0; issue_en = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (regs_flat !== model_flat() || busy !== m_busy) begin
      errors++; $display("FAIL async_after: got busy %h expected 0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_all();
    test_reg_zero();
    test_lifecycle();
    test_set_clear_same();
    test_independent();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
